// File: rtl/reg_alloc_map_v2_if.sv
// Allocation / release handshake bundle between the thread manager (master)
// and the register allocation unit (slave).
//   alloc_*   : allocation request with valid/ready, done/fail response pulses
//   dealloc_* : warp-exit release request with valid/ready, done response pulse
//   warp_busy : per-warp mask of warps currently being allocated or released
//   free_count: number of free physical register-file entries
interface reg_alloc_map_v2_if #(
    parameter int NUM_WARPS      = 8,
    parameter int SLOTS_PER_WARP = 4,
    parameter int NUM_ENTRIES    = 16
);
    localparam int WW  = $clog2(NUM_WARPS);
    localparam int NSW = $clog2(SLOTS_PER_WARP) + 1;
    localparam int FCW = $clog2(NUM_ENTRIES + 1);

    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [WW-1:0]        alloc_warp;
    logic [NSW-1:0]       alloc_nslots;
    logic                 alloc_done;
    logic                 alloc_fail;
    logic                 dealloc_valid;
    logic                 dealloc_ready;
    logic [WW-1:0]        dealloc_warp;
    logic                 dealloc_done;
    logic [NUM_WARPS-1:0] warp_busy;
    logic [FCW-1:0]       free_count;

    modport master (
        output alloc_valid, alloc_warp, alloc_nslots, dealloc_valid, dealloc_warp,
        input  alloc_ready, alloc_done, alloc_fail, dealloc_ready, dealloc_done,
               warp_busy, free_count
    );

    modport slave (
        input  alloc_valid, alloc_warp, alloc_nslots, dealloc_valid, dealloc_warp,
        output alloc_ready, alloc_done, alloc_fail, dealloc_ready, dealloc_done,
               warp_busy, free_count
    );
endinterface

// File: rtl/reg_alloc_map_v2.sv
// Register allocation and mapping unit: owns the free map of physical
// register-file entries and the per-warp slot LUT, allocates/releases a warp's
// slots one per cycle, and translates architectural registers to physical
// row/bank on two read ports and one writeback port.
//   clk, rst           : clock, synchronous active-high reset
//   bus (slave)        : alloc/dealloc handshake, warp_busy, free_count
//   rd0_*, rd1_*, wr_* : combinational lookup ports (warp, reg -> row, bank, mapped)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | accepting requests; dealloc wins when both are valid
// ALLOC    | writing one LUT slot per cycle with the lowest free entry
// DEALLOC  | visiting all SLOTS_PER_WARP slots, freeing the valid ones
module reg_alloc_map_v2 #(
    parameter int NUM_WARPS      = 8,
    parameter int SLOTS_PER_WARP = 4,
    parameter int NUM_ENTRIES    = 16,
    localparam int WW  = $clog2(NUM_WARPS),
    localparam int SW  = $clog2(SLOTS_PER_WARP),
    localparam int NSW = SW + 1,
    localparam int EW  = $clog2(NUM_ENTRIES),
    localparam int RW  = $clog2(NUM_ENTRIES / 2),
    localparam int FCW = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    reg_alloc_map_v2_if.slave         bus,
    input  logic [WW-1:0]             rd0_warp,
    input  logic [NSW-1:0]            rd0_reg,
    output logic [RW-1:0]             rd0_row,
    output logic [1:0]                rd0_bank,
    output logic                      rd0_mapped,
    input  logic [WW-1:0]             rd1_warp,
    input  logic [NSW-1:0]            rd1_reg,
    output logic [RW-1:0]             rd1_row,
    output logic [1:0]                rd1_bank,
    output logic                      rd1_mapped,
    input  logic [WW-1:0]             wr_warp,
    input  logic [NSW-1:0]            wr_reg,
    output logic [RW-1:0]             wr_row,
    output logic [1:0]                wr_bank,
    output logic                      wr_mapped
);
    typedef enum logic [1:0] {ST_IDLE, ST_ALLOC, ST_DEALLOC} state_t;

    state_t                 state_q, state_d;
    logic [WW-1:0]          warp_q, warp_d;
    logic [SW-1:0]          slot_q, slot_d;
    logic [NSW-1:0]         nslots_q, nslots_d;
    logic [FCW-1:0]         free_count_q, free_count_d;
    logic [NUM_ENTRIES-1:0] free_map_q, free_map_d;
    logic                   lut_valid_q [NUM_WARPS][SLOTS_PER_WARP];
    logic                   lut_valid_d [NUM_WARPS][SLOTS_PER_WARP];
    logic [EW-1:0]          lut_entry_q [NUM_WARPS][SLOTS_PER_WARP];
    logic [EW-1:0]          lut_entry_d [NUM_WARPS][SLOTS_PER_WARP];
    logic                   alloc_done_q, alloc_done_d;
    logic                   alloc_fail_q, alloc_fail_d;
    logic                   dealloc_done_q, dealloc_done_d;

    logic [EW-1:0]          low_free;
    logic                   warp_holds;
    logic                   alloc_reject;
    logic                   alloc_ready;
    logic                   dealloc_ready;
    logic [NUM_WARPS-1:0]   warp_busy;

    // Downward scan so the last hit is the lowest-index free entry.
    always_comb begin
        low_free = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (free_map_q[i]) low_free = EW'(i);
        end
    end

    always_comb begin
        warp_holds = 1'b0;
        for (int s = 0; s < SLOTS_PER_WARP; s++) begin
            warp_holds = warp_holds | lut_valid_q[bus.alloc_warp][s];
        end
    end

    assign alloc_reject = (int'(bus.alloc_nslots) > SLOTS_PER_WARP) ||
                          (int'(bus.alloc_nslots) > int'(free_count_q)) ||
                          warp_holds;

    always_comb begin
        state_d        = state_q;
        warp_d         = warp_q;
        slot_d         = slot_q;
        nslots_d       = nslots_q;
        free_count_d   = free_count_q;
        free_map_d     = free_map_q;
        lut_valid_d    = lut_valid_q;
        lut_entry_d    = lut_entry_q;
        alloc_done_d   = 1'b0;
        alloc_fail_d   = 1'b0;
        dealloc_done_d = 1'b0;
        alloc_ready    = 1'b0;
        dealloc_ready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                dealloc_ready = 1'b1;
                alloc_ready   = !bus.dealloc_valid;
                if (bus.dealloc_valid) begin
                    warp_d  = bus.dealloc_warp;
                    slot_d  = '0;
                    state_d = ST_DEALLOC;
                end else if (bus.alloc_valid) begin
                    if (alloc_reject) begin
                        alloc_fail_d = 1'b1;
                    end else if (bus.alloc_nslots == '0) begin
                        alloc_done_d = 1'b1;
                    end else begin
                        warp_d   = bus.alloc_warp;
                        nslots_d = bus.alloc_nslots;
                        slot_d   = '0;
                        state_d  = ST_ALLOC;
                    end
                end
            end
            ST_ALLOC: begin
                // The accept-time reject check guarantees a free entry exists here.
                lut_valid_d[warp_q][slot_q] = 1'b1;
                lut_entry_d[warp_q][slot_q] = low_free;
                free_map_d[low_free]        = 1'b0;
                free_count_d                = free_count_q - FCW'(1);
                slot_d                      = slot_q + SW'(1);
                if (int'(slot_q) + 1 == int'(nslots_q)) begin
                    state_d      = ST_IDLE;
                    alloc_done_d = 1'b1;
                end
            end
            ST_DEALLOC: begin
                if (lut_valid_q[warp_q][slot_q]) begin
                    free_map_d[lut_entry_q[warp_q][slot_q]] = 1'b1;
                    lut_valid_d[warp_q][slot_q]             = 1'b0;
                    free_count_d                            = free_count_q + FCW'(1);
                end
                slot_d = slot_q + SW'(1);
                if (int'(slot_q) == SLOTS_PER_WARP - 1) begin
                    state_d        = ST_IDLE;
                    dealloc_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            warp_q         <= '0;
            slot_q         <= '0;
            nslots_q       <= '0;
            free_count_q   <= FCW'(NUM_ENTRIES);
            free_map_q     <= '1;
            lut_valid_q    <= '{default: '0};
            lut_entry_q    <= '{default: '0};
            alloc_done_q   <= 1'b0;
            alloc_fail_q   <= 1'b0;
            dealloc_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            warp_q         <= warp_d;
            slot_q         <= slot_d;
            nslots_q       <= nslots_d;
            free_count_q   <= free_count_d;
            free_map_q     <= free_map_d;
            lut_valid_q    <= lut_valid_d;
            lut_entry_q    <= lut_entry_d;
            alloc_done_q   <= alloc_done_d;
            alloc_fail_q   <= alloc_fail_d;
            dealloc_done_q <= dealloc_done_d;
        end
    end

    // The done cycle is back in IDLE, so busy covers exactly the ALLOC/DEALLOC cycles.
    always_comb begin
        warp_busy = '0;
        if (state_q != ST_IDLE) warp_busy[warp_q] = 1'b1;
    end

    assign bus.alloc_ready   = alloc_ready;
    assign bus.dealloc_ready = dealloc_ready;
    assign bus.alloc_done    = alloc_done_q;
    assign bus.alloc_fail    = alloc_fail_q;
    assign bus.dealloc_done  = dealloc_done_q;
    assign bus.warp_busy     = warp_busy;
    assign bus.free_count    = free_count_q;

    // Returns {row, bank, mapped}; unmapped slots read as all zero.
    function automatic logic [RW+2:0] lookup(input logic [WW-1:0] w, input logic [NSW-1:0] r);
        logic [SW-1:0] s;
        logic [EW-1:0] e;
        s = r[NSW-1:1];
        e = lut_entry_q[w][s];
        if (lut_valid_q[w][s]) lookup = {RW'(e >> 1), e[0], r[0], 1'b1};
        else                   lookup = '0;
    endfunction

    assign {rd0_row, rd0_bank, rd0_mapped} = lookup(rd0_warp, rd0_reg);
    assign {rd1_row, rd1_bank, rd1_mapped} = lookup(rd1_warp, rd1_reg);
    assign {wr_row, wr_bank, wr_mapped}    = lookup(wr_warp, wr_reg);
endmodule

// File: tb/tb_reg_alloc_map_v2.sv
module tb_reg_alloc_map_v2;
    localparam int NW  = 8;
    localparam int SPW = 4;
    localparam int NE  = 16;
    localparam int K_ADONE = 0;
    localparam int K_AFAIL = 1;
    localparam int K_DDONE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_alloc_map_v2_if #(.NUM_WARPS(NW), .SLOTS_PER_WARP(SPW), .NUM_ENTRIES(NE)) bus ();

    logic [2:0] rd0_warp, rd1_warp, wr_warp;
    logic [2:0] rd0_reg, rd1_reg, wr_reg;
    logic [2:0] rd0_row, rd1_row, wr_row;
    logic [1:0] rd0_bank, rd1_bank, wr_bank;
    logic       rd0_mapped, rd1_mapped, wr_mapped;

    reg_alloc_map_v2 #(.NUM_WARPS(NW), .SLOTS_PER_WARP(SPW), .NUM_ENTRIES(NE)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rd0_warp(rd0_warp), .rd0_reg(rd0_reg), .rd0_row(rd0_row), .rd0_bank(rd0_bank), .rd0_mapped(rd0_mapped),
        .rd1_warp(rd1_warp), .rd1_reg(rd1_reg), .rd1_row(rd1_row), .rd1_bank(rd1_bank), .rd1_mapped(rd1_mapped),
        .wr_warp(wr_warp), .wr_reg(wr_reg), .wr_row(wr_row), .wr_bank(wr_bank), .wr_mapped(wr_mapped)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    // Reference model of the allocator state.
    bit m_free  [NE];
    bit m_valid [NW][SPW];
    int m_entry [NW][SPW];
    int m_fc;

    task automatic model_reset();
        for (int e = 0; e < NE; e++) m_free[e] = 1'b1;
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < SPW; s++) begin
                m_valid[w][s] = 1'b0;
                m_entry[w][s] = 0;
            end
        m_fc = NE;
    endtask

    task automatic model_alloc(input int w, input int n);
        bit held;
        held = 1'b0;
        for (int s = 0; s < SPW; s++) held |= m_valid[w][s];
        if (n > SPW || n > m_fc || held) begin
            exp_q.push_back(K_AFAIL);
        end else begin
            for (int s = 0; s < n; s++) begin
                int e;
                e = 0;
                while (!m_free[e]) e++;
                m_free[e]     = 1'b0;
                m_valid[w][s] = 1'b1;
                m_entry[w][s] = e;
                m_fc--;
            end
            exp_q.push_back(K_ADONE);
        end
    endtask

    task automatic model_dealloc(input int w);
        for (int s = 0; s < SPW; s++)
            if (m_valid[w][s]) begin
                m_free[m_entry[w][s]] = 1'b1;
                m_valid[w][s] = 1'b0;
                m_fc++;
            end
        exp_q.push_back(K_DDONE);
    endtask

    function automatic logic [5:0] exp_lk(input int w, input int r);
        int s;
        s = r / 2;
        if (m_valid[w][s]) return {3'(m_entry[w][s] / 2), 1'(m_entry[w][s] % 2), 1'(r % 2), 1'b1};
        return 6'd0;
    endfunction

    // Scoreboard: pops the expected response whenever the DUT pulses one.
    int mon_obs, mon_exp;
    always @(negedge clk) begin
        if (!rst && (bus.alloc_done || bus.alloc_fail || bus.dealloc_done)) begin
            mon_obs = bus.dealloc_done ? K_DDONE : (bus.alloc_fail ? K_AFAIL : K_ADONE);
            checks++;
            if (int'(bus.alloc_done) + int'(bus.alloc_fail) + int'(bus.dealloc_done) > 1) begin
                errors++;
                $display("FAIL resp_multi got done=%0b fail=%0b ddone=%0b expected one pulse",
                         bus.alloc_done, bus.alloc_fail, bus.dealloc_done);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected got kind %0d expected none at %0t", mon_obs, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_obs !== mon_exp) begin
                    errors++;
                    $display("FAIL resp_kind got %0d expected %0d at %0t", mon_obs, mon_exp, $time);
                end
            end
        end
    end

    task automatic issue_alloc(input int w, input int n);
        int t;
        t = 0;
        while (!bus.alloc_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
            errors++;
            $display("FAIL alloc_ready_timeout got ready=0 expected 1 within 100 cycles");
        end
        bus.alloc_valid  = 1'b1;
        bus.alloc_warp   = 3'(w);
        bus.alloc_nslots = 3'(n);
        model_alloc(w, n);
        @(posedge clk);
        @(negedge clk);
        bus.alloc_valid = 1'b0;
    endtask

    task automatic issue_dealloc(input int w);
        int t;
        t = 0;
        while (!bus.dealloc_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
            errors++;
            $display("FAIL dealloc_ready_timeout got ready=0 expected 1 within 100 cycles");
        end
        bus.dealloc_valid = 1'b1;
        bus.dealloc_warp  = 3'(w);
        model_dealloc(w);
        @(posedge clk);
        @(negedge clk);
        bus.dealloc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !bus.alloc_ready) && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL idle_timeout got %0d pending responses expected 0", exp_q.size());
        end
    endtask

    task automatic check_lookups();
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < 8; r++) begin
                rd0_warp = 3'(w);     rd0_reg = 3'(r);
                rd1_warp = 3'(w);     rd1_reg = 3'(7 - r);
                wr_warp  = 3'(7 - w); wr_reg  = 3'(r);
                #1;
                checks++;
                if ({rd0_row, rd0_bank, rd0_mapped} !== exp_lk(w, r)) begin
                    errors++;
                    $display("FAIL lk_rd0 w%0d r%0d got %b expected %b", w, r,
                             {rd0_row, rd0_bank, rd0_mapped}, exp_lk(w, r));
                end
                checks++;
                if ({rd1_row, rd1_bank, rd1_mapped} !== exp_lk(w, 7 - r)) begin
                    errors++;
                    $display("FAIL lk_rd1 w%0d r%0d got %b expected %b", w, 7 - r,
                             {rd1_row, rd1_bank, rd1_mapped}, exp_lk(w, 7 - r));
                end
                checks++;
                if ({wr_row, wr_bank, wr_mapped} !== exp_lk(7 - w, r)) begin
                    errors++;
                    $display("FAIL lk_wr w%0d r%0d got %b expected %b", 7 - w, r,
                             {wr_row, wr_bank, wr_mapped}, exp_lk(7 - w, r));
                end
            end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.alloc_valid = 1'b0; bus.alloc_warp = '0; bus.alloc_nslots = '0;
        bus.dealloc_valid = 1'b0; bus.dealloc_warp = '0;
        rd0_warp = '0; rd0_reg = '0; rd1_warp = '0; rd1_reg = '0; wr_warp = '0; wr_reg = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if (bus.free_count !== 5'd16) begin
            errors++; $display("FAIL reset_free_count got %0d expected 16", bus.free_count);
        end
        checks++;
        if ({bus.alloc_ready, bus.dealloc_ready} !== 2'b11) begin
            errors++; $display("FAIL reset_ready got %b expected 11", {bus.alloc_ready, bus.dealloc_ready});
        end
        checks++;
        if ({bus.warp_busy, bus.alloc_done, bus.alloc_fail, bus.dealloc_done} !== 11'd0) begin
            errors++; $display("FAIL reset_busy_pulses got %b expected 0",
                               {bus.warp_busy, bus.alloc_done, bus.alloc_fail, bus.dealloc_done});
        end
        check_lookups();
    endtask

    task automatic test_first_alloc();
        issue_alloc(2, 3);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if ({bus.warp_busy, bus.alloc_done} !== {(k < 4) ? 8'h04 : 8'h00, k == 4}) begin
                errors++;
                $display("FAIL first_alloc_timing cycle %0d got busy=%h done=%b expected busy=%h done=%b",
                         k, bus.warp_busy, bus.alloc_done, (k < 4) ? 8'h04 : 8'h00, k == 4);
            end
            if (k < 4) @(negedge clk);
        end
        checks++;
        if (bus.free_count !== 5'd13) begin
            errors++; $display("FAIL first_alloc_free_count got %0d expected 13", bus.free_count);
        end
        rd0_warp = 3'd2; rd0_reg = 3'd5;
        #1;
        checks++;
        if ({rd0_row, rd0_bank, rd0_mapped} !== {3'd1, 2'b01, 1'b1}) begin
            errors++; $display("FAIL first_alloc_w2r5 got %b expected 001011", {rd0_row, rd0_bank, rd0_mapped});
        end
        @(negedge clk);
        wait_idle();
        check_lookups();
    endtask

    task automatic test_fill();
        issue_alloc(0, 4); wait_idle();
        issue_alloc(1, 4); wait_idle();
        issue_alloc(3, 4); wait_idle();
        issue_alloc(4, 1); wait_idle();
        checks++;
        if (bus.free_count !== 5'(m_fc) || m_fc != 0) begin
            errors++; $display("FAIL fill_free_count got %0d expected 0", bus.free_count);
        end
        issue_alloc(5, 1);
        checks++;
        if ({bus.alloc_fail, bus.alloc_done} !== 2'b10) begin
            errors++; $display("FAIL fill_reject got fail/done %b expected 10", {bus.alloc_fail, bus.alloc_done});
        end
        wait_idle();
        checks++;
        if (bus.free_count !== 5'd0) begin
            errors++; $display("FAIL fill_after_reject got %0d expected 0", bus.free_count);
        end
        check_lookups();
    endtask

    task automatic test_dealloc();
        issue_dealloc(1);
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if ({bus.warp_busy, bus.dealloc_done} !== {(k <= 4) ? 8'h02 : 8'h00, k == 5}) begin
                errors++;
                $display("FAIL dealloc_timing cycle %0d got busy=%h done=%b expected busy=%h done=%b",
                         k, bus.warp_busy, bus.dealloc_done, (k <= 4) ? 8'h02 : 8'h00, k == 5);
            end
            if (k < 5) @(negedge clk);
        end
        checks++;
        if (bus.free_count !== 5'd4) begin
            errors++; $display("FAIL dealloc_free_count got %0d expected 4", bus.free_count);
        end
        wait_idle();
        issue_alloc(5, 2);
        wait_idle();
        rd0_warp = 3'd5; rd0_reg = 3'd0; rd1_warp = 3'd5; rd1_reg = 3'd2;
        #1;
        checks++;
        if ({rd0_row, rd0_bank, rd0_mapped, rd1_row, rd1_bank, rd1_mapped} !==
            {3'd3, 2'b10, 1'b1, 3'd4, 2'b00, 1'b1}) begin
            errors++; $display("FAIL realloc_entries got %b expected 011101100001",
                               {rd0_row, rd0_bank, rd0_mapped, rd1_row, rd1_bank, rd1_mapped});
        end
        @(negedge clk);
        check_lookups();
    endtask

    task automatic test_priority();
        bus.alloc_valid = 1'b1; bus.alloc_warp = 3'd6; bus.alloc_nslots = 3'd1;
        bus.dealloc_valid = 1'b1; bus.dealloc_warp = 3'd4;
        model_dealloc(4);
        model_alloc(6, 1);
        #1;
        checks++;
        if ({bus.alloc_ready, bus.dealloc_ready} !== 2'b01) begin
            errors++; $display("FAIL prio_ready got %b expected 01", {bus.alloc_ready, bus.dealloc_ready});
        end
        @(posedge clk);
        @(negedge clk);
        bus.dealloc_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if ({bus.warp_busy, bus.dealloc_done, bus.alloc_ready} !==
                {(k <= 4) ? 8'h10 : 8'h00, k == 5, k == 5}) begin
                errors++;
                $display("FAIL prio_dealloc cycle %0d got busy=%h ddone=%b aready=%b", k,
                         bus.warp_busy, bus.dealloc_done, bus.alloc_ready);
            end
            if (k < 5) @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        bus.alloc_valid = 1'b0;
        checks++;
        if ({bus.warp_busy, bus.alloc_done} !== {8'h40, 1'b0}) begin
            errors++; $display("FAIL prio_alloc_busy got busy=%h done=%b expected 40/0", bus.warp_busy, bus.alloc_done);
        end
        @(negedge clk);
        checks++;
        if ({bus.warp_busy, bus.alloc_done} !== {8'h00, 1'b1}) begin
            errors++; $display("FAIL prio_alloc_done got busy=%h done=%b expected 00/1", bus.warp_busy, bus.alloc_done);
        end
        wait_idle();
        check_lookups();
    endtask

    task automatic test_reject();
        issue_alloc(2, 2);
        checks++;
        if ({bus.alloc_fail, bus.alloc_done} !== 2'b10) begin
            errors++; $display("FAIL reject_held got fail/done %b expected 10", {bus.alloc_fail, bus.alloc_done});
        end
        issue_alloc(7, 5);
        checks++;
        if ({bus.alloc_fail, bus.alloc_done} !== 2'b10) begin
            errors++; $display("FAIL reject_too_many got fail/done %b expected 10", {bus.alloc_fail, bus.alloc_done});
        end
        issue_alloc(7, 0);
        checks++;
        if ({bus.alloc_fail, bus.alloc_done, bus.warp_busy} !== {2'b01, 8'h00}) begin
            errors++; $display("FAIL zero_alloc got fail/done/busy %b expected 0100000000",
                               {bus.alloc_fail, bus.alloc_done, bus.warp_busy});
        end
        wait_idle();
        checks++;
        if (bus.free_count !== 5'(m_fc)) begin
            errors++; $display("FAIL reject_free_count got %0d expected %0d", bus.free_count, m_fc);
        end
        check_lookups();
    endtask

    task automatic test_reset_mid_alloc();
        issue_dealloc(0);
        wait_idle();
        issue_alloc(7, 4);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.free_count !== 5'd4) begin
            errors++; $display("FAIL mid_alloc_free_count got %0d expected 4", bus.free_count);
        end
        rd0_warp = 3'd7; rd0_reg = 3'd1; rd1_warp = 3'd7; rd1_reg = 3'd3; wr_warp = 3'd7; wr_reg = 3'd4;
        #1;
        checks++;
        if ({rd0_mapped, rd1_mapped, wr_mapped} !== 3'b110) begin
            errors++; $display("FAIL mid_alloc_partial got %b expected 110", {rd0_mapped, rd1_mapped, wr_mapped});
        end
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.free_count, bus.alloc_ready, bus.dealloc_ready, bus.warp_busy} !== {5'd16, 2'b11, 8'h00}) begin
            errors++; $display("FAIL mid_reset_state got fc=%0d ready=%b busy=%h expected 16/11/00",
                               bus.free_count, {bus.alloc_ready, bus.dealloc_ready}, bus.warp_busy);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({bus.alloc_done, bus.alloc_fail, bus.dealloc_done} !== 3'b000) begin
                errors++; $display("FAIL mid_reset_pulse cycle %0d got %b expected 000", k,
                                   {bus.alloc_done, bus.alloc_fail, bus.dealloc_done});
            end
            @(negedge clk);
        end
        check_lookups();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_alloc();
        test_fill();
        test_dealloc();
        test_priority();
        test_reject();
        test_reset_mid_alloc();
        wait_idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
